// File: rtl/delta_sigma_mc.sv
// Multi-channel delta-sigma DAC modulator with a shared valid/ready write port.
// Define DS_SECOND_ORDER_EN for a second-order error-feedback loop per channel.
module delta_sigma_mc #(
  parameter int IN_BITS  = 12,
  parameter int CHANNELS = 4,
  parameter int DIV      = 1,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int NW = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW-1:0]       in_chan,
  input  logic [IN_BITS-1:0]  in_data,
  output logic [CHANNELS-1:0] out,
  output logic                tick
);

  logic [IN_BITS-1:0]  r_level  [CHANNELS];
  logic [IN_BITS-1:0]  r_shadow [CHANNELS];
  logic [CHANNELS-1:0] r_pend;
  logic [CHANNELS-1:0] r_out;
  logic [NW-1:0]       r_cnt;
  logic                r_tick;

  logic                w_inrange;
  logic                w_pend_sel;
  logic                w_accept;
  logic                w_upd;
  logic [IN_BITS-1:0]  w_lvl [CHANNELS];
  logic [CHANNELS-1:0] w_nxt_out;

  always_comb begin
    w_inrange  = 1'b0;
    w_pend_sel = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_chan == CW'(c)) begin
        w_inrange  = 1'b1;
        w_pend_sel = r_pend[c];
      end
    end
  end

  assign in_ready = ena & w_inrange & ~w_pend_sel;
  assign w_accept = in_valid & in_ready;
  assign w_upd    = ena && (r_cnt == NW'(DIV - 1));

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_lvl[c] = r_pend[c] ? r_shadow[c] : r_level[c];
    end
  end

`ifdef DS_SECOND_ORDER_EN
  localparam int WW = IN_BITS + 6;
  localparam int SW = IN_BITS + 4;
  localparam logic signed [WW-1:0] LIM  = WW'(2 ** (IN_BITS + 2));
  localparam logic signed [WW-1:0] NLIM = -LIM;
  localparam logic signed [WW-1:0] FBV  = WW'(2 ** IN_BITS);

  logic signed [SW-1:0] r_i1 [CHANNELS];
  logic signed [SW-1:0] r_i2 [CHANNELS];
  logic signed [WW-1:0] w_i1n [CHANNELS];
  logic signed [WW-1:0] w_i2n [CHANNELS];

  function automatic logic signed [WW-1:0] sat(
    input logic signed [WW-1:0] v
  );
    if (v > LIM)
      return LIM;
    else if (v < NLIM)
      return NLIM;
    return v;
  endfunction

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      logic signed [WW-1:0] fb;
      fb = r_out[c] ? FBV : '0;
      w_i1n[c] = sat(WW'(r_i1[c])
        + $signed({6'd0, w_lvl[c]}) - fb);
      w_i2n[c] = sat(WW'(r_i2[c]) + w_i1n[c] - fb);
      w_nxt_out[c] = ~w_i2n[c][WW-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_i1[c] <= '0;
        r_i2[c] <= '0;
      end
    end else if (w_upd) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_i1[c] <= SW'(w_i1n[c]);
        r_i2[c] <= SW'(w_i2n[c]);
      end
    end
  end
`else
  logic [IN_BITS-1:0] r_acc [CHANNELS];
  logic [IN_BITS:0]   w_sum [CHANNELS];

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      w_sum[c]     = {1'b0, r_acc[c]} + {1'b0, w_lvl[c]};
      w_nxt_out[c] = w_sum[c][IN_BITS];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++)
        r_acc[c] <= '0;
    end else if (w_upd) begin
      for (int c = 0; c < CHANNELS; c++)
        r_acc[c] <= w_sum[c][IN_BITS-1:0];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_level[c]  <= '0;
        r_shadow[c] <= '0;
      end
      r_pend <= '0;
      r_out  <= '0;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_upd;
      if (ena)
        r_cnt <= w_upd ? '0 : r_cnt + NW'(1);
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_upd) begin
          r_level[c] <= w_lvl[c];
          r_pend[c]  <= 1'b0;
          r_out[c]   <= w_nxt_out[c];
        end
        // a write landing on an update cycle keeps its pending flag
        if (w_accept && in_chan == CW'(c)) begin
          r_shadow[c] <= in_data;
          r_pend[c]   <= 1'b1;
        end
      end
    end
  end

  assign out  = r_out;
  assign tick = r_tick;

endmodule

// File: tb/tb_delta_sigma_mc.sv
// Bench for delta_sigma_mc: two configurations driven by shared stimulus
// and compared every cycle against a behavioural model.
module tb_delta_sigma_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_chan = '0;
  logic [11:0] in_data = '0;
  logic        rdy0, rdy1, tick0, tick1;
  logic [3:0]  out0;
  logic [2:0]  out1;

  always #5 clk = ~clk;

  delta_sigma_mc #(.IN_BITS(12), .CHANNELS(4), .DIV(1)) u0 (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid),
    .in_ready(rdy0), .in_chan(in_chan), .in_data(in_data),
    .out(out0), .tick(tick0));

  delta_sigma_mc #(.IN_BITS(12), .CHANNELS(3), .DIV(4)) u1 (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid),
    .in_ready(rdy1), .in_chan(in_chan), .in_data(in_data),
    .out(out1), .tick(tick1));

  int n_chk = 0;
  int n_fail = 0;
  int CH[2] = '{4, 3};
  int DV[2] = '{1, 4};

  int       lv[2][4];
  int       sh[2][4];
  int       acc[2][4];
  bit       pend[2][4];
  int       cnt[2];
  bit [3:0] mout[2];
  bit       mtick[2];
  bit       chk_on = 1'b0;

  task automatic check(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ready(int d);
    return ena && (int'(in_chan) < CH[d]) && !pend[d][in_chan];
  endfunction

  // model: levels, write buffer and accumulator as plain integers
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 4; c++) begin
          lv[d][c] = 0; sh[d][c] = 0; acc[d][c] = 0; pend[d][c] = 0;
        end
        cnt[d] = 0; mout[d] = '0; mtick[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit r, u;
        r = m_ready(d);
        u = ena && (cnt[d] == DV[d] - 1);
        if (u) begin
          for (int c = 0; c < CH[d]; c++) begin
            int l, s;
            l = pend[d][c] ? sh[d][c] : lv[d][c];
            lv[d][c] = l;
            pend[d][c] = 0;
            s = acc[d][c] + l;
            mout[d][c] = (s >= 4096);
            acc[d][c] = s % 4096;
          end
        end
        mtick[d] = u;
        if (ena) cnt[d] = (cnt[d] + 1) % DV[d];
        if (in_valid && r) begin
          sh[d][in_chan] = int'(in_data);
          pend[d][in_chan] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("out0", int'(out0), int'(mout[0]));
      check("out1", int'(out1), int'(mout[1][2:0]));
      check("tick0", int'(tick0), int'(mtick[0]));
      check("tick1", int'(tick1), int'(mtick[1]));
      check("ready0", int'(rdy0), int'(m_ready(0)));
      check("ready1", int'(rdy1), int'(m_ready(1)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int seq[4];
  int ones0, ones1, ones2, n, c;

  initial begin
    repeat (3) cyc();
    rst = 1'b1;
    ena = 1'b1;
    chk_on = 1'b1;

    // idle after reset
    repeat (64) cyc();
    @(negedge clk);
    check("idle_out", int'(out0), 0);
    check("idle_tick", int'(tick0), 1);
    check("idle_ready", int'(rdy0), 1);
    cyc();

    // write on an update cycle: old level used first, then 0,1,0,1
    in_valid = 1'b1; in_chan = 2'd0; in_data = 12'd2048;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seq[k] = int'(out0[0]);
    end
    for (int k = 0; k < 4; k++) check("alt_seq", seq[k], k % 2);

    // extreme levels
    cyc();
    in_valid = 1'b1; in_chan = 2'd1; in_data = 12'd4095;
    cyc();
    in_chan = 2'd2; in_data = 12'd1;
    cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    ones0 = 0; ones1 = 0; ones2 = 0;
    for (int k = 0; k < 4096; k++) begin
      @(negedge clk);
      if (k < 1024) ones0 += int'(out0[0]);
      ones1 += int'(out0[1]);
      ones2 += int'(out0[2]);
    end
    check("duty_2048", ones0, 512);
    check("duty_4095", ones1, 4095);
    check("duty_1", ones2, 1);

    // back-to-back writes to one channel on the DIV=4 instance
    cyc();
    in_valid = 1'b1; in_chan = 2'd0; in_data = 12'd100;
    @(posedge clk); #1;
    in_data = 12'd200;
    n = 0;
    forever begin
      @(negedge clk);
      if (rdy1 || n >= 20) break;
      n++;
      @(posedge clk); #1;
    end
    check("stall_ready_with_tick", int'(tick1), 1);
    check("stall_len_ok", int'(n >= 1 && n <= 4), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;

    c = 0;
    do begin @(negedge clk); c++; end while (!tick1 && c < 20);
    c = 0;
    do begin @(negedge clk); c++; end while (!tick1 && c < 20);
    check("tick_period", c, 4);

    // out-of-range channel on the 3-channel instance
    @(posedge clk); #1;
    in_valid = 1'b1; in_chan = 2'd3; in_data = 12'd777;
    @(negedge clk);
    check("oor_ready", int'(rdy1), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // freeze
    ena = 1'b0;
    repeat (10) cyc();
    @(negedge clk);
    check("frozen_tick", int'(tick0), 0);
    @(posedge clk); #1;
    ena = 1'b1;

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      int sel;
      ena = ($urandom % 10) != 0;
      in_valid = $urandom % 2;
      in_chan = 2'($urandom % 4);
      sel = $urandom % 4;
      in_data = (sel == 0) ? 12'd0 : (sel == 1) ? 12'd4095 : 12'($urandom);
      cyc();
    end
    ena = 1'b1;
    in_valid = 1'b0;
    repeat (8) cyc();

    // asynchronous reset mid-cycle
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("async_out0", int'(out0), 0);
    check("async_out1", int'(out1), 0);
    check("async_tick0", int'(tick0), 0);
    check("async_tick1", int'(tick1), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (50) cyc();

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/delta_sigma_mc.md
# delta_sigma_mc

Multi-channel, parametrised delta-sigma DAC modulator. Holds one input level per channel, accepted through a valid/ready write port, and produces one pulse-density output bit per channel. Outputs update on a programmable tick derived from the system clock. It is the successor of the single-channel first-order modulator and drives banks of RC-filtered output pins, such as audio or LED dimming, from one shared write interface.

## Interface
- IN_BITS, 12: width of each unsigned input level.
- CHANNELS, 4: number of independent modulators (≥1).
- DIV, 1: modulator update period in enabled clk cycles (≥1).
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- ena  input  1  global enable; low freezes all state.
- in_valid  input  1  write request.
- in_ready  output  1  write accepted when in_valid && in_ready.
- in_chan  input  $clog2(CHANNELS) (min 1)  target channel.
- in_data  input  IN_BITS  new unsigned level.
- out  output  CHANNELS  registered modulator bits, out[c] for channel c.
- tick  output  1  registered, high for one cycle after each modulator update.

## Operation
- Per-channel state:
  - level[c] is the committed level.
  - shadow[c] and pending[c] are the write buffer.
  - acc[c] is the IN_BITS-bit accumulator.
  - out[c] is the output bit.
- Write port:
  - in_ready = ena && (in_chan < CHANNELS) && !pending[in_chan].
  - On accept: shadow[in_chan] <= in_data and pending[in_chan] <= 1.
  - An out-of-range in_chan is never accepted.
- Divider:
  - cnt counts 0..DIV-1 on enabled cycles.
  - Update strobe upd = ena && cnt==DIV-1, after which cnt wraps to 0.
- On upd, each channel uses lvl = pending[c] ? shadow[c] : level[c]. Then:
  - level[c] <= lvl
  - pending[c] <= 0
  - sum = {1'b0,acc[c]} + lvl (IN_BITS+1 bits)
  - out[c] <= sum[IN_BITS]
  - acc[c] <= sum[IN_BITS-1:0]
- Long-run duty of out[c] is exactly lvl/2^IN_BITS.
- Accept and upd in the same cycle:
  - The update uses the pre-write state.
  - The write lands in shadow and sets pending. The set wins over upd's clear for that channel.
- ena=0: no accept, no update, cnt held, out held, tick=0.

## Timing
- Reset values: level, shadow, acc, cnt all 0. pending=0, out=0, tick=0.
- in_ready is combinational from ena, in_chan and pending. There is no combinational path from in_valid to in_ready.
- tick is asserted the cycle after upd, coincident with the new out values.
- Write latency: a sample accepted at cycle t affects out starting at the first tick after the first upd at a cycle > t.
- Only one outstanding write per channel. A second write to the same channel stalls (in_ready=0) until the next upd clears pending.
- Reset asserted mid-operation clears everything immediately, including pending writes.

## Configuration
- DS_SECOND_ORDER_EN undefined: first-order accumulator as above.
- DS_SECOND_ORDER_EN defined: each channel is a second-order error-feedback loop.
  - Registers: signed i1[c] and i2[c], IN_BITS+4 bits each.
  - On upd:
    - fb = out[c] ? 2^IN_BITS : 0
    - i1n = i1 + lvl − fb
    - i2n = i2 + i1n − fb, each saturated to ±2^(IN_BITS+2)
    - out[c] <= (i2n >= 0)
  - acc is removed. Interface, handshake and timing are unchanged.
  - Reset: i1 = i2 = 0.
  - Long-run duty equals lvl/2^IN_BITS within 1/2^IN_BITS.

## Test plan
- Reset, no writes, DIV=1, 64 cycles → out=0 on all channels, tick high every cycle from cycle 2, in_ready=1 for valid in_chan.
- Write ch0=2048 (IN_BITS=12), DIV=1 → out[0] sequence after commit 0,1,0,1…; exactly 512 ones in 1024 ticks.
- Write ch1=4095 and ch2=1 → out[1] has 4095 ones per 4096 ticks; out[2] has exactly one 1 per 4096 ticks.
- DIV=4, write ch0 twice back-to-back → second write sees in_ready=0 until the cycle after the next upd, then is accepted; tick period 4 cycles.
- Write presented on the same cycle as upd → that tick uses the old level; the new level is used at the next upd; pending=1 afterward.
- in_chan=CHANNELS (when CHANNELS not a power of two, e.g. 3 with in_chan=3) → in_ready=0, no state change. ena=0 for 10 cycles → out and cnt frozen. rst pulse mid-run → all outputs 0 asynchronously.
